imem_loader: RTL

- Writer side of the instruction-memory interface that the riscv core reads through its fetch path.
- Accepts a byte stream (valid/ready) carrying a length header and little-endian instruction words, and stores them in an internal word array.
- Holds the core in reset until loading completes.
- Then serves registered instruction reads addressed by the core PC, one-cycle latency, matching the fetch dff stage.

---
 rtl/imem_loader.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: writer side of the core's instruction memory.
// A byte stream carrying a 16-bit little-endian word count and then little-endian
// instruction words is written into an internal word array. The core is held in
// reset until the load completes. After that, the array serves registered reads
// addressed by the core PC with one cycle of latency.
// Optional feature: define LOADER_CHECKSUM_EN to require an XOR trailer byte
// after the data. A wrong trailer sends the loader to the error state.
module imem_loader #(
  parameter int N_WORDS = 21,
  parameter int CNT_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  input  logic [31:0] pc_i,
  output logic [31:0] inst_o,
  output logic        core_rst_n_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int          AW  = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, CSUM, DONE, ERR} state_t;
`else
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, DONE, ERR} state_t;
`endif

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   len_q;
  logic [CNT_W-1:0]   word_idx;
  logic [1:0]         byte_cnt;
  logic [23:0]        word_buf;
  logic [31:0]        mem [N_WORDS];
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]         xor_q;
`endif

  logic               xfer;
  logic [CNT_W-1:0]   hdr_len;
  logic               last_word;
  logic               mem_we;
  logic [AW-1:0]      wr_idx;
  logic [AW-1:0]      rd_idx;
  logic [31:0]        pc_word;
  logic               rd_hit;

  // Handshake qualifiers, next-state decode and the read-hit condition.
  always_comb begin
    xfer       = byte_valid_i && byte_ready_o;
    hdr_len    = CNT_W'({byte_i, len_q[7:0]});
    last_word  = ((word_idx + CNT_W'(1)) == len_q);
    mem_we     = (state == DATA) && xfer && !start_i && (byte_cnt == 2'd3);
    wr_idx     = word_idx[AW-1:0];
    pc_word    = {2'b00, pc_i[31:2]};
    rd_idx     = pc_i[AW+1:2];
    rd_hit     = (state == DONE) && (pc_word < 32'(len_q)) && (pc_word < 32'(N_WORDS));
    next_state = state;
    if (start_i) begin
      next_state = HDR0;
    end else begin
      case (state)
        HDR0: if (xfer) next_state = HDR1;
        HDR1: begin
          if (xfer) begin
            if (hdr_len == '0) begin
`ifdef LOADER_CHECKSUM_EN
              next_state = CSUM;
`else
              next_state = DONE;
`endif
            end else if (hdr_len > CNT_W'(N_WORDS)) begin
              next_state = ERR;
            end else begin
              next_state = DATA;
            end
          end
        end
        DATA: begin
          if (xfer && (byte_cnt == 2'd3) && last_word) begin
`ifdef LOADER_CHECKSUM_EN
            next_state = CSUM;
`else
            next_state = DONE;
`endif
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CSUM: if (xfer) next_state = (byte_i == xor_q) ? DONE : ERR;
`endif
        default: next_state = state;
      endcase
    end
  end

  // FSM state, session counters, registered status outputs and the read port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      byte_ready_o <= 1'b0;
      core_rst_n_o <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      inst_o       <= NOP;
      len_q        <= '0;
      word_idx     <= '0;
      byte_cnt     <= 2'd0;
      word_buf     <= 24'd0;
`ifdef LOADER_CHECKSUM_EN
      xor_q        <= 8'd0;
`endif
    end else begin
      state        <= next_state;
`ifdef LOADER_CHECKSUM_EN
      byte_ready_o <= (next_state == HDR0) || (next_state == HDR1) ||
                      (next_state == DATA) || (next_state == CSUM);
`else
      byte_ready_o <= (next_state == HDR0) || (next_state == HDR1) ||
                      (next_state == DATA);
`endif
      done_o       <= (next_state == DONE);
      err_o        <= (next_state == ERR);
      core_rst_n_o <= (next_state == DONE);
      inst_o       <= rd_hit ? mem[rd_idx] : NOP;

      if (start_i) begin
        len_q    <= '0;
        word_idx <= '0;
        byte_cnt <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
        xor_q    <= 8'd0;
`endif
      end else if (xfer) begin
        case (state)
          HDR0: len_q[7:0] <= byte_i;
          HDR1: len_q      <= hdr_len;
          DATA: begin
            byte_cnt <= byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            xor_q    <= xor_q ^ byte_i;
`endif
            case (byte_cnt)
              2'd0:    word_buf[7:0]   <= byte_i;
              2'd1:    word_buf[15:8]  <= byte_i;
              2'd2:    word_buf[23:16] <= byte_i;
              default: word_idx        <= word_idx + CNT_W'(1);
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  // Storage write: the completed little-endian word lands on its fourth byte.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_idx] <= {byte_i, word_buf};
  end

endmodule
